sine_table_loader: RTL and testbench



---
 rtl/sine_pkg.sv | 21 ++
 rtl/sine_csum_acc.sv | 35 +++
 rtl/sine_table_loader.sv | 191 +++++++++++++++++++
 tb/tb_sine_table_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine sample table: sizes, loader states and
// the packing rule for the flattened table bus read by the sample-select mux.
package sine_pkg;

    localparam int SINE_WIDTH = 16;
    localparam int SINE_DEPTH = 64;
    localparam int SINE_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } loader_state_e;

    // Entry k of the flattened table occupies bits [k*w + w-1 : k*w].
    function automatic int unsigned sine_slice_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/sine_csum_acc.sv
// Wrapping running-sum register used to verify a loaded sine table.
// clr has priority over en; the sum wraps modulo 2^WIDTH.
module sine_csum_acc
    import sine_pkg::*;
#(
    parameter int WIDTH = SINE_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    // Next sum: clear, accumulate, or hold.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + din;
        end
    end

    // Sum register.
    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/sine_table_loader.sv
// Writer side of the sine sample table. Samples arrive one per handshake
// over a valid/ready stream and fill a DEPTH-entry register bank, which is
// presented in parallel on tbl_flat. tbl_valid marks a complete table.
// Optional feature: define SINE_LOADER_CSUM_EN to require a trailing
// checksum word (16-bit wrapping sum of the samples) after each load;
// without it err is tied low and LOAD finishes straight into DONE.
module sine_table_loader
    import sine_pkg::*;
#(
    parameter int WIDTH = SINE_WIDTH,
    parameter int DEPTH = SINE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH*DEPTH-1:0]   tbl_flat,
    output logic                     tbl_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic                     err
);

    localparam int IDX_W = $clog2(DEPTH);

    loader_state_e    state_q;
    loader_state_e    state_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] wr_idx_d;
    logic             s_ready_q;
    logic             s_ready_d;
    logic             busy_q;
    logic             busy_d;
    logic             tbl_valid_q;
    logic             tbl_valid_d;
    logic [WIDTH-1:0] entry_q [DEPTH];

    logic hs;
    logic wr_en;
    logic load_start;
    logic last_entry;

    // s_ready is a register, so the handshake never loops back through s_valid.
    assign hs         = s_valid & s_ready_q;
    assign last_entry = (wr_idx_q == IDX_W'(DEPTH - 1));

`ifdef SINE_LOADER_CSUM_EN
    logic             err_q;
    logic             err_d;
    logic             csum_clr;
    logic             csum_match;
    logic [WIDTH-1:0] csum;

    // Reset also clears the sum so no stale total survives an aborted load.
    assign csum_clr   = ~rst_n | load_start;
    assign csum_match = (s_data == csum);

    sine_csum_acc #(
        .WIDTH (WIDTH)
    ) u_csum_acc (
        .clk (clk),
        .clr (csum_clr),
        .en  (wr_en),
        .din (s_data),
        .sum (csum)
    );
`endif

    // Next-state logic: load sequencing, write index and error flag.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        wr_en      = 1'b0;
        load_start = 1'b0;
`ifdef SINE_LOADER_CSUM_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    wr_idx_d   = '0;
                    load_start = 1'b1;
`ifdef SINE_LOADER_CSUM_EN
                    err_d      = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_en = 1'b1;
                    if (last_entry) begin
                        wr_idx_d = '0;
`ifdef SINE_LOADER_CSUM_EN
                        state_d  = CSUM;
`else
                        state_d  = DONE;
`endif
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
`ifdef SINE_LOADER_CSUM_EN
                if (hs) begin
                    if (csum_match) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is registered.
    always_comb begin
        s_ready_d   = 1'b0;
        busy_d      = 1'b0;
        tbl_valid_d = 1'b0;
        case (state_d)
            LOAD, CSUM: begin
                s_ready_d = 1'b1;
                busy_d    = 1'b1;
            end
            DONE:    tbl_valid_d = 1'b1;
            default: ;
        endcase
    end

    // State, index and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            tbl_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            tbl_valid_q <= tbl_valid_d;
        end
    end

    // Entry bank: cleared on reset so no partial table survives, written on LOAD handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx_q] <= s_data;
        end
    end

`ifdef SINE_LOADER_CSUM_EN
    // Sticky checksum error, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign tbl_flat[sine_slice_lsb(k, WIDTH) +: WIDTH] = entry_q[k];
    end

    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign tbl_valid = tbl_valid_q;
    assign wr_idx    = wr_idx_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Bench for sine_table_loader: directed load sequences with tabulated
// expected entries, plus a randomized phase against a behavioural model.
module tb_sine_table_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [15:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [1023:0] tbl_flat;
    logic          tbl_valid;
    logic          busy;
    logic [5:0]    wr_idx;
    logic          err;

`ifdef SINE_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    sine_table_loader #(
        .WIDTH (16),
        .DEPTH (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .tbl_flat  (tbl_flat),
        .tbl_valid (tbl_valid),
        .busy      (busy),
        .wr_idx    (wr_idx),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: table contents, accepted-sample count, phase flags.
    logic [15:0] m_tbl [64];
    int          m_count;
    bit          m_load;
    bit          m_csum;
    bit          m_done;
    bit          m_err;
    logic [15:0] m_sum;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } ent_t;

    ent_t tab [6];

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 16'h0000;
        m_count = 0;
        m_load  = 0;
        m_csum  = 0;
        m_done  = 0;
        m_err   = 0;
        m_sum   = 16'h0000;
    endfunction

    function automatic void m_step(input bit st, input bit sv, input logic [15:0] sd);
        bit accepting;
        if (!rst_n) begin
            m_reset();
            return;
        end
        accepting = m_load || m_csum;
        if (accepting && sv) begin
            if (m_load) begin
                m_tbl[m_count] = sd;
                m_sum = m_sum + sd;
                m_count++;
                if (m_count == 64) begin
                    m_count = 0;
                    m_load  = 0;
                    if (CSUM_ON) m_csum = 1;
                    else         m_done = 1;
                end
            end else begin
                m_csum = 0;
                if (sd == m_sum) m_done = 1;
                else             m_err  = 1;
            end
        end else if (!accepting && st) begin
            m_load  = 1;
            m_done  = 0;
            m_err   = 0;
            m_count = 0;
            m_sum   = 16'h0000;
        end
    endfunction

    task automatic check_model();
        logic [1023:0] ef;
        bit            act;
        logic [9:0]    got_c;
        logic [9:0]    exp_c;
        act = m_load || m_csum;
        for (int k = 0; k < 64; k++) ef[k*16 +: 16] = m_tbl[k];
        got_c = {s_ready, busy, tbl_valid, err, wr_idx};
        exp_c = {act, act, m_done, m_err, 6'(m_count)};
        total++;
        if (got_c !== exp_c) begin
            bad++;
            $display("FAIL ctrl cyc=%0d got rdy=%b busy=%b vld=%b err=%b idx=%0d want rdy=%b busy=%b vld=%b err=%b idx=%0d",
                     cyc, got_c[9], got_c[8], got_c[7], got_c[6], got_c[5:0],
                     exp_c[9], exp_c[8], exp_c[7], exp_c[6], exp_c[5:0]);
        end
        total++;
        if (tbl_flat !== ef) begin
            bad++;
            for (int k = 0; k < 64; k++) begin
                if (tbl_flat[k*16 +: 16] !== ef[k*16 +: 16]) begin
                    $display("FAIL table cyc=%0d entry=%0d got=%h want=%h",
                             cyc, k, tbl_flat[k*16 +: 16], ef[k*16 +: 16]);
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1ns later.
    task automatic step(input bit st, input bit sv, input logic [15:0] sd);
        start   = st;
        s_valid = sv;
        s_data  = sd;
        @(posedge clk);
        m_step(st, sv, sd);
        cyc++;
        #1;
        check_model();
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d, input int gap);
        repeat (gap) step(1'b0, 1'b0, 16'($urandom));
        step(1'b0, 1'b1, d);
    endtask

    task automatic finish_csum();
        if (CSUM_ON) step(1'b0, 1'b1, m_sum);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        m_reset();

        tab[0] = '{idx: 0,  val: 16'h0000};
        tab[1] = '{idx: 1,  val: 16'h0101};
        tab[2] = '{idx: 17, val: 16'h1111};
        tab[3] = '{idx: 32, val: 16'h2020};
        tab[4] = '{idx: 62, val: 16'h3E3E};
        tab[5] = '{idx: 63, val: 16'h3F3F};

        // Reset held for 3 cycles, with noise on the stream inputs.
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'h1234);
        step(1'b1, 1'b0, 16'h5678);
        chk("rst_flat_zero", 32'(tbl_flat == '0), 32'd1);
        chk("rst_valid", 32'(tbl_valid), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(wr_idx), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Idle: stream data is ignored without start.
        step(1'b0, 1'b1, 16'hDEAD);
        chk("idle_ready", 32'(s_ready), 32'd0);

        // Continuous full load of k*0x0101.
        step(1'b1, 1'b0, 16'h0000);
        chk("start_ready", 32'(s_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 63; k++) feed(16'(k * 16'h0101), 0);
        chk("pre_last_valid", 32'(tbl_valid), 32'd0);
        feed(16'h3F3F, 0);
        chk("last_valid", 32'(tbl_valid), CSUM_ON ? 32'd0 : 32'd1);
        chk("last_ready", 32'(s_ready), CSUM_ON ? 32'd1 : 32'd0);
        finish_csum();
        chk("load1_valid", 32'(tbl_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("load1_entry%0d", tab[i].idx),
                32'(tbl_flat[tab[i].idx*16 +: 16]), 32'(tab[i].val));
        end

        // Backpressure: s_valid pattern 1,0,0,1 repeating.
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 64; k++) begin
            feed(16'(k), (k % 2 == 1) ? 2 : 0);
            if (k == 9) chk("bp_idx", 32'(wr_idx), 32'd10);
        end
        finish_csum();
        chk("bp_entry5", 32'(tbl_flat[5*16 +: 16]), 32'h0005);
        chk("bp_entry63", 32'(tbl_flat[63*16 +: 16]), 32'h003F);
        chk("bp_valid", 32'(tbl_valid), 32'd1);

        // Stray start while busy is ignored.
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 64; k++) begin
            if (k == 20) begin
                chk("stray_pre_idx", 32'(wr_idx), 32'd20);
                step(1'b1, 1'b1, 16'(16'hA000 + k));
                chk("stray_idx", 32'(wr_idx), 32'd21);
                step(1'b1, 1'b0, 16'h0000);
                chk("stray_busy", 32'(busy), 32'd1);
            end else begin
                feed(16'(16'hA000 + k), 0);
            end
        end
        finish_csum();
        chk("stray_valid", 32'(tbl_valid), 32'd1);
        chk("stray_entry20", 32'(tbl_flat[20*16 +: 16]), 32'hA014);

        // Reload from DONE, then reset mid-load.
        step(1'b1, 1'b0, 16'h0000);
        chk("reload_valid_drop", 32'(tbl_valid), 32'd0);
        for (int k = 0; k < 30; k++) feed(16'(16'h7700 + k), 0);
        chk("reload_new29", 32'(tbl_flat[29*16 +: 16]), 32'h771D);
        chk("reload_old40", 32'(tbl_flat[40*16 +: 16]), 32'hA028);
        chk("reload_idx30", 32'(wr_idx), 32'd30);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 16'h7777);
        chk("midrst_flat_zero", 32'(tbl_flat == '0), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd0);
        chk("midrst_idx", 32'(wr_idx), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 16'h1111);
        chk("post_rst_idle", 32'(busy), 32'd0);

`ifdef SINE_LOADER_CSUM_EN
        // Checksum: 64 x 0x0400 wraps to 0x0000.
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 64; k++) feed(16'h0400, 0);
        step(1'b0, 1'b1, 16'h0000);
        chk("csum_ok_valid", 32'(tbl_valid), 32'd1);
        chk("csum_ok_err", 32'(err), 32'd0);
        step(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 64; k++) feed(16'h0400, k % 3);
        step(1'b0, 1'b1, 16'h0001);
        chk("csum_bad_err", 32'(err), 32'd1);
        chk("csum_bad_valid", 32'(tbl_valid), 32'd0);
        chk("csum_bad_busy", 32'(busy), 32'd0);
        chk("csum_bad_entry63", 32'(tbl_flat[63*16 +: 16]), 32'h0400);
        step(1'b0, 1'b1, 16'h0000);
        chk("csum_err_sticky", 32'(err), 32'd1);
        step(1'b1, 1'b0, 16'h0000);
        chk("csum_err_clear", 32'(err), 32'd0);
        for (int k = 0; k < 64; k++) feed(16'($urandom), 0);
        finish_csum();
        chk("csum_rand_valid", 32'(tbl_valid), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          sv;
            logic [15:0] sd;
            st = ($urandom_range(0, 29) == 0);
            sv = ($urandom_range(0, 2) != 0);
            sd = 16'($urandom);
            if (m_csum && $urandom_range(0, 1) == 1) sd = m_sum;
            rst_n = ($urandom_range(0, 699) != 0);
            step(st, sv, sd);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
